serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder: adds two WIDTH-bit operands LSB-first, one bit per clock.
- One full-adder cell plus a carry flip-flop, sequenced by a small FSM with start/busy/done handshake.
- Companion to the combinational ripple-borrow subtractor datapath. Used where area matters more than latency, and as an arithmetic cross-check against the combinational blocks in the bench.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising edge of clk; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- sum  output  WIDTH  result register; valid while done=1 and held until next accept.
- carry_out  output  1  final carry from MSB; valid with sum.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Reset (reset=1 at rising edge): state=IDLE; sum=0, carry_out=0, busy=0, done=0; internal shift registers, carry FF and bit counter cleared. Overrides start. Reset during RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1: load a_sh<=a, b_sh<=b, carry<=carry_in (0), count<=0, sum<=0 -> RUN. IDLE, start=0: stay.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry; c = majority(a_sh[0], b_sh[0], carry).
  - Shift s into sum from the MSB side (sum <= {s, sum[WIDTH-1:1]}).
  - a_sh, b_sh shift right by 1; carry<=c; count<=count+1.
  - When count==WIDTH-1: carry_out<=c, go to DONE.
- DONE: done=1 for exactly this one cycle; busy=0. Next edge: start=1 -> accept (as IDLE) and go to RUN; otherwise -> IDLE.
- sum and carry_out are held unchanged after DONE until the next accept. On accept, sum is cleared and carry_out is cleared.
- start while RUN is ignored. Operands are not re-sampled; a and b may change freely after the accepting edge.
- Latency: accept at edge k; done high in the cycle after edge k+WIDTH. Back-to-back throughput is one operation per WIDTH+1 cycles.
- busy = (state==RUN); done = (state==DONE); both are registered-state decodes.
- Arithmetic: unsigned modulo 2^WIDTH; carry_out is bit WIDTH of a+b. Counter width is $clog2(WIDTH)+1; no wrap occurs inside an operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on the accepting edge.
  - sub=1 computes a-b as a + ~b + 1: b_sh loaded with ~b, carry FF loaded with 1.
  - carry_out=1 means no borrow (a>=b unsigned); carry_out=0 means borrow.
  - sub=0 behaves exactly as the base block.
- Not defined: no sub port; carry FF always loaded with 0 on accept.

Test Plan:
- reset held 2 cycles, then released -> sum=0000, carry_out=0, busy=0, done=0; start asserted in the reset cycle has no effect.
- a=1001, b=0100, start pulse -> busy for 4 cycles, done pulse in the 5th cycle, sum=1101, carry_out=0; values held 3 further idle cycles.
- a=1111, b=1110 -> sum=1101, carry_out=1. Then, with start=1 during DONE, a=0111, b=1111 -> re-accepted with no IDLE gap; sum=0110, carry_out=1.
- a=0011, b=0001 accepted; start=1 and a=1111 driven during RUN -> ignored, result sum=0100, carry_out=0, single done pulse.
- Operation started, reset asserted after 2 RUN cycles -> IDLE next cycle, all outputs 0, no done pulse; next op a=0101, b=0101 -> sum=1010, carry_out=0.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=1001, b=0100 -> sum=0101, carry_out=1; sub=1, a=0111, b=1111 -> sum=1000, carry_out=0 (borrow).

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first ripple adder (one full-adder cell + carry FF).
// Latency: accept at edge k, done pulse in the cycle after edge k+WIDTH; one op per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; accepted only in IDLE or DONE (DONE+start chains with no gap).
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input computing a-b as a + ~b + 1.

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  // Operand transform applied at accept: plain add, or add of ~b with carry-in 1 for subtract.
  logic [WIDTH-1:0] b_load;
  logic             carry_in;

  // Select the B operand and carry-in loaded on the accepting edge.
  always_comb begin
    b_load   = b;
    carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load   = ~b;
      carry_in = 1'b1;
    end
`endif
  end

  // Full-adder cell on the current LSBs.
  logic fa_s, fa_c;
  always_comb begin
    fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  end

  // Next-state and datapath update: accept in IDLE/DONE, one bit per edge in RUN.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_in;
          count_d = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_c;
        count_d = count_q + 1'b1;
        if (count_q == LAST_BIT) begin
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=4).
// Inputs are driven and outputs sampled 1ns after each rising edge.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a, b;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic [3:0] sum;
  logic       carry_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then wait (bounded) for done and check the result.
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] es, input logic ec, input string tag);
    int n, nbusy;
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
    chk({tag, " busy_after_accept"}, busy, 1);
    n = 0; nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    chk({tag, " done_seen"}, done, 1);
    chk({tag, " busy_cycles"}, nbusy, 4);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " sum"}, sum, es);
    chk({tag, " carry_out"}, carry_out, ec);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b1; a = 4'b1001; b = 4'b0100;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    // Reset held two cycles with start asserted.
    tick(); tick();
    chk("rst sum", sum, 0);
    chk("rst carry_out", carry_out, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("post_rst busy", busy, 0);
    chk("post_rst done", done, 0);

    // 1001 + 0100 = 1101, no carry; result held while idle.
    do_op(4'b1001, 4'b0100, 4'b1101, 1'b0, "add1");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold done", done, 0);
      chk("hold busy", busy, 0);
      chk("hold sum", sum, 4'b1101);
      chk("hold carry_out", carry_out, 0);
    end

    // 1111 + 1110 = 1_1101, then back-to-back 0111 + 1111 = 1_0110.
    do_op(4'b1111, 4'b1110, 4'b1101, 1'b1, "add2");
    do_op(4'b0111, 4'b1111, 4'b0110, 1'b1, "b2b");
    tick();
    chk("b2b done_pulse_end", done, 0);

    // start during RUN is ignored: 0011 + 0001 = 0100.
    a = 4'b0011; b = 4'b0001; start = 1'b1;
    tick();
    chk("ign busy", busy, 1);
    a = 4'b1111;
    tick();
    tick();
    chk("ign still_busy", busy, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("ign done_seen", done, 1);
    chk("ign sum", sum, 4'b0100);
    chk("ign carry_out", carry_out, 0);
    tick();
    chk("ign single_pulse", done, 0);
    chk("ign idle", busy, 0);
    chk("ign hold sum", sum, 4'b0100);

    // Reset after two RUN cycles aborts with no done pulse.
    a = 4'b1111; b = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort carry_out", carry_out, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n++;
    end
    chk("abort no_done", n, 0);
    do_op(4'b0101, 4'b0101, 4'b1010, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
    tick();
    sub = 1'b1;
    do_op(4'b1001, 4'b0100, 4'b0101, 1'b1, "sub_noborrow");
    do_op(4'b0111, 4'b1111, 4'b1000, 1'b0, "sub_borrow");
    sub = 1'b0;
    do_op(4'b0111, 4'b1111, 4'b0110, 1'b1, "sub0_add");
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
